multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 253 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle MIPS-style datapath. One instruction walks
// FETCH -> DECODE -> (class-specific states) -> FETCH. All outputs except
// aluControl and pcEn are registered alongside the state, so they change only
// on the clock edge that enters the state they belong to.
//
// Build option:
//   MULTICYCLE_JUMP_EN  - when defined, opcode 000010 (j) goes to the JUMP
//                         state; otherwise it is treated as an illegal opcode
//                         and pcSrc never takes the value 10.
//
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   opcode     in   6  instr[31:26] from the instruction register
//   funct      in   6  instr[5:0]
//   zFlag      in   1  ALU equality flag
//   pcEn       out  1  PC load enable = pcWrite | (branch & zFlag)
//   iorD       out  1  memory address select (1 = ALUOut)
//   irWrite    out  1  instruction register write enable
//   memWrite   out  1  memory write enable
//   regDst     out  1  register file write address select (1 = rd)
//   memToReg   out  1  register write data select (1 = memory data)
//   regWrite   out  1  register file write enable
//   aluSrcA    out  1  ALU A select (1 = regA, 0 = PC)
//   aluSrcB    out  2  ALU B select: 00 regB, 01 4, 10 imm, 11 imm<<2
//   aluControl out  2  00 AND, 01 XOR, 10 ADD, 11 SUB
//   pcSrc      out  2  00 ALU result, 01 ALUOut, 10 jump target
//   state      out  4  current state, for debug
// ----------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zFlag,
    output logic       pcEn,
    output logic       iorD,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluControl,
    output logic [1:0] pcSrc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
`ifdef MULTICYCLE_JUMP_EN
        StAddiWb = 4'd10,
        StJump   = 4'd11
`else
        StAddiWb = 4'd10
`endif
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [5:0] OpJ     = 6'b000010;
`endif

    state_e     r_state;
    state_e     w_state_next;

    logic       r_pc_write;
    logic       r_branch;
    logic       r_iord;
    logic       r_ir_write;
    logic       r_mem_write;
    logic       r_reg_dst;
    logic       r_mem_to_reg;
    logic       r_reg_write;
    logic       r_alu_src_a;
    logic [1:0] r_alu_src_b;
    logic [1:0] r_pc_src;

    logic       w_pc_write;
    logic       w_branch;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_src;

    logic       w_funct_legal;
    logic [1:0] w_funct_alu;

    // R-type funct decode; anything unrecognised aborts the instruction in EXEC.
    always_comb begin
        w_funct_legal = 1'b1;
        w_funct_alu   = 2'b10;
        unique case (funct)
            6'b100100: w_funct_alu = 2'b00;
            6'b100110: w_funct_alu = 2'b01;
            6'b100000: w_funct_alu = 2'b10;
            6'b100010: w_funct_alu = 2'b11;
            default: begin
                w_funct_legal = 1'b0;
                w_funct_alu   = 2'b10;
            end
        endcase
    end

    always_comb begin
        w_state_next = StFetch;
        unique case (r_state)
            StFetch: w_state_next = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpRtype:     w_state_next = StExec;
                    OpLw, OpSw:  w_state_next = StMemAdr;
                    OpBeq:       w_state_next = StBranch;
                    OpAddi:      w_state_next = StAddiEx;
`ifdef MULTICYCLE_JUMP_EN
                    OpJ:         w_state_next = StJump;
`endif
                    default:     w_state_next = StFetch;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything but sw is a load.
            StMemAdr: w_state_next = (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:  w_state_next = StMemWb;
            StExec:   w_state_next = w_funct_legal ? StAluWb : StFetch;
            StAddiEx: w_state_next = StAddiWb;
            default:  w_state_next = StFetch;
        endcase
        if (reset) begin
            w_state_next = StFetch;
        end
    end

    // Output values for the state being entered; latched with the state so
    // each output is glitch-free for the whole cycle.
    always_comb begin
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        unique case (w_state_next)
            StFetch: begin
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                w_alu_src_b = 2'b01;
            end
            StDecode: w_alu_src_b = 2'b11;
            StMemAdr, StAddiEx: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            StMemRd: w_iord = 1'b1;
            StMemWr: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            StMemWb: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            StAluWb: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            StAddiWb: w_reg_write = 1'b1;
            StExec:   w_alu_src_a = 1'b1;
            StBranch: begin
                w_alu_src_a = 1'b1;
                w_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            StJump: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
        r_pc_write   <= w_pc_write;
        r_branch     <= w_branch;
        r_iord       <= w_iord;
        r_ir_write   <= w_ir_write;
        r_mem_write  <= w_mem_write;
        r_reg_dst    <= w_reg_dst;
        r_mem_to_reg <= w_mem_to_reg;
        r_reg_write  <= w_reg_write;
        r_alu_src_a  <= w_alu_src_a;
        r_alu_src_b  <= w_alu_src_b;
        r_pc_src     <= w_pc_src;
    end

    // aluControl is a decode of funct in EXEC, so it stays combinational.
    always_comb begin
        aluControl = 2'b10;
        if (r_state == StExec) begin
            aluControl = w_funct_alu;
        end else if (r_state == StBranch) begin
            aluControl = 2'b11;
        end
    end

    // State-changing strobes are masked while reset is held.
    assign pcEn     = ~reset & (r_pc_write | (r_branch & zFlag));
    assign irWrite  = ~reset & r_ir_write;
    assign memWrite = ~reset & r_mem_write;
    assign regWrite = ~reset & r_reg_write;

    assign iorD     = r_iord;
    assign regDst   = r_reg_dst;
    assign memToReg = r_mem_to_reg;
    assign aluSrcA  = r_alu_src_a;
    assign aluSrcB  = r_alu_src_b;
    assign pcSrc    = r_pc_src;
    assign state    = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zFlag = 1'b0;
    logic       pcEn, iorD, irWrite, memWrite, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluControl, pcSrc;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MULTICYCLE_JUMP_EN
    localparam bit JumpEn = 1'b1;
`else
    localparam bit JumpEn = 1'b0;
`endif

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zFlag      (zFlag),
        .pcEn       (pcEn),
        .iorD       (iorD),
        .irWrite    (irWrite),
        .memWrite   (memWrite),
        .regDst     (regDst),
        .memToReg   (memToReg),
        .regWrite   (regWrite),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .aluControl (aluControl),
        .pcSrc      (pcSrc),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] pc_src;
    } ovec_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         lat;
        int         n_regw;
        int         n_memw;
        int         n_pcen;
    } vec_t;

    vec_t tbl[12];
    int   g_seq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ovec_t sample_out();
        ovec_t o;
        o.st = state; o.pc_en = pcEn; o.iord = iorD; o.ir_write = irWrite;
        o.mem_write = memWrite; o.reg_dst = regDst; o.mem_to_reg = memToReg;
        o.reg_write = regWrite; o.alu_src_a = aluSrcA; o.alu_src_b = aluSrcB;
        o.alu_control = aluControl; o.pc_src = pcSrc;
        return o;
    endfunction

    // Expected outputs for a state, straight from the per-state output lists.
    function automatic ovec_t exp_vec(input int st, input logic [5:0] fn, input logic z);
        ovec_t o;
        o = '0;
        o.st = st[3:0];
        o.alu_control = 2'b10;
        case (st)
            0: begin o.ir_write = 1; o.pc_en = 1; o.alu_src_b = 2'b01; end
            1: o.alu_src_b = 2'b11;
            2, 9: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3: o.iord = 1;
            4: begin o.mem_to_reg = 1; o.reg_write = 1; end
            5: begin o.iord = 1; o.mem_write = 1; end
            6: begin
                o.alu_src_a = 1;
                if (fn == 6'b100100) o.alu_control = 2'b00;
                else if (fn == 6'b100110) o.alu_control = 2'b01;
                else if (fn == 6'b100010) o.alu_control = 2'b11;
            end
            7: begin o.reg_dst = 1; o.reg_write = 1; end
            8: begin o.alu_src_a = 1; o.alu_control = 2'b11; o.pc_src = 2'b01; o.pc_en = z; end
            10: o.reg_write = 1;
            11: begin o.pc_src = 2'b10; o.pc_en = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // State path of one instruction, by instruction class.
    task automatic fill_seq(input logic [5:0] op, input logic [5:0] fn);
        bit legal_fn;
        legal_fn = (fn == 6'b100100) || (fn == 6'b100110) || (fn == 6'b100000) ||
                   (fn == 6'b100010);
        g_seq = '{0, 1};
        case (op)
            6'b000000: begin g_seq.push_back(6); if (legal_fn) g_seq.push_back(7); end
            6'b100011: begin g_seq.push_back(2); g_seq.push_back(3); g_seq.push_back(4); end
            6'b101011: begin g_seq.push_back(2); g_seq.push_back(5); end
            6'b000100: g_seq.push_back(8);
            6'b001000: begin g_seq.push_back(9); g_seq.push_back(10); end
            6'b000010: if (JumpEn) g_seq.push_back(11);
            default: ;
        endcase
    endtask

    // Starts just after a rising edge with the DUT in FETCH; ends the same way.
    task automatic run_model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input bit rnd_z);
        int seq[$];
        fill_seq(op, fn);
        seq = g_seq;
        opcode = op;
        funct  = fn;
        zFlag  = z;
        foreach (seq[k]) begin
            if (rnd_z) zFlag = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("op%02h_fn%02h_st%0d", op, fn, seq[k]),
                  32'(sample_out()), 32'(exp_vec(seq[k], fn, zFlag)));
            @(posedge clk);
            #1;
        end
        check($sformatf("op%02h_return_fetch", op), 32'(state), 32'd0);
    endtask

    task automatic run_table(input vec_t v, input int idx);
        int cyc = 0;
        int nr = 0;
        int nm = 0;
        int np = 0;
        opcode = v.op;
        funct  = v.fn;
        zFlag  = v.z;
        do begin
            @(negedge clk);
            nr += int'(regWrite);
            nm += int'(memWrite);
            np += int'(pcEn);
            cyc++;
            @(posedge clk);
            #1;
        end while (state != 4'd0 && cyc < 12);
        check($sformatf("tbl%0d_latency", idx), 32'(cyc), 32'(v.lat));
        check($sformatf("tbl%0d_regwrite_cnt", idx), 32'(nr), 32'(v.n_regw));
        check($sformatf("tbl%0d_memwrite_cnt", idx), 32'(nm), 32'(v.n_memw));
        check($sformatf("tbl%0d_pcen_cnt", idx), 32'(np), 32'(v.n_pcen));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{6'b000000, 6'b100100, 1'b0, 4, 1, 0, 1};
        tbl[1]  = '{6'b000000, 6'b100110, 1'b0, 4, 1, 0, 1};
        tbl[2]  = '{6'b000000, 6'b100000, 1'b1, 4, 1, 0, 1};
        tbl[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 1, 0, 1};
        tbl[4]  = '{6'b100011, 6'b000000, 1'b0, 5, 1, 0, 1};
        tbl[5]  = '{6'b101011, 6'b000000, 1'b0, 4, 0, 1, 1};
        tbl[6]  = '{6'b001000, 6'b000000, 1'b0, 4, 1, 0, 1};
        tbl[7]  = '{6'b000100, 6'b000000, 1'b1, 3, 0, 0, 2};
        tbl[8]  = '{6'b000100, 6'b000000, 1'b0, 3, 0, 0, 1};
        tbl[9]  = '{6'b000010, 6'b000000, 1'b0, JumpEn ? 3 : 2, 0, 0, JumpEn ? 2 : 1};
        tbl[10] = '{6'b111111, 6'b100000, 1'b0, 2, 0, 0, 1};
        tbl[11] = '{6'b000000, 6'b000000, 1'b0, 3, 0, 0, 1};

        // Reset: state is FETCH but strobes are masked.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_pcen", 32'(pcEn), 32'd0);
        check("reset_irwrite", 32'(irWrite), 32'd0);
        check("reset_regwrite", 32'(regWrite), 32'd0);
        check("reset_memwrite", 32'(memWrite), 32'd0);
        check("reset_alusrcb", 32'(aluSrcB), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed instructions with full per-cycle output check.
        run_model(6'b100011, 6'b000000, 1'b0, 1'b0);
        run_model(6'b000000, 6'b100010, 1'b0, 1'b0);
        run_model(6'b000100, 6'b000000, 1'b1, 1'b0);
        run_model(6'b000100, 6'b000000, 1'b0, 1'b0);
        run_model(6'b000010, 6'b000000, 1'b0, 1'b0);
        run_model(6'b111111, 6'b000000, 1'b0, 1'b0);
        run_model(6'b000000, 6'b000000, 1'b0, 1'b0);

        foreach (tbl[i]) run_table(tbl[i], i);

        // pcEn follows zFlag combinationally in BRANCH.
        opcode = 6'b000100;
        zFlag  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        zFlag = 1'b1;
        #1;
        check("branch_pcen_z1", 32'(pcEn), 32'd1);
        check("branch_pcsrc", 32'(pcSrc), 32'd1);
        zFlag = 1'b0;
        #1;
        check("branch_pcen_z0", 32'(pcEn), 32'd0);
        @(posedge clk); #1;
        check("branch_return_fetch", 32'(state), 32'd0);

        // Reset asserted while in MEMWR.
        opcode = 6'b101011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("memwr_state", 32'(state), 32'd5);
        reset = 1'b1;
        #1;
        check("memwr_reset_memwrite", 32'(memWrite), 32'd0);
        check("memwr_reset_iord", 32'(iorD), 32'd1);
        @(posedge clk); #1;
        check("memwr_reset_state", 32'(state), 32'd0);
        check("memwr_reset_irwrite", 32'(irWrite), 32'd0);
        reset = 1'b0;
        #1;
        check("post_reset_irwrite", 32'(irWrite), 32'd1);
        check("post_reset_pcen", 32'(pcEn), 32'd1);

        // Reset in MEMRD of a lw, then a normal instruction.
        opcode = 6'b100011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("memrd_state", 32'(state), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        check("memrd_reset_state", 32'(state), 32'd0);
        reset = 1'b0;
        run_model(6'b001000, 6'b000000, 1'b0, 1'b0);

        // Randomized instruction stream against the model.
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int sel;
            sel = $urandom_range(0, 8);
            case (sel)
                0, 1: op = 6'b000000;
                2: op = 6'b100011;
                3: op = 6'b101011;
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: fn = 6'b100100;
                1: fn = 6'b100110;
                2: fn = 6'b100000;
                3: fn = 6'b100010;
                default: fn = 6'($urandom);
            endcase
            run_model(op, fn, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
